pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program-counter unit for the RV32I core. Holds the fetch PC,
//  selects next PC (sequential / branch / jalr) and adds stall, debug halt/resume, misaligned-
//  target trapping and a taken-transfer counter. Sits between control unit/sign-extend and
//  instruction memory; PC drives the instruction-memory address.
// PARAMETERS
//  ADDR_WIDTH    32  width of PC, ImmOp, rd1, vectors
//  RESET_VECTOR  0   PC value loaded on reset
//  TRAP_VECTOR   4   PC value loaded on misaligned-target exception
//  CNT_WIDTH     16  width of redirect_count
//  TRACE_DEPTH   8   trace entries (power of 2, >=2); used only with PC_TRACE_EN
// PORTS
//  clk             in   1           clock, all state updates on rising edge
//  rst             in   1           synchronous, active-high reset
//  stall           in   1           hold PC (hazard/memory wait)
//  PCsrc           in   1           branch/jal taken: target = PC + ImmOp
//  jalrmuxSel      in   1           jalr: target = (rd1 + ImmOp) & ~1
//  ImmOp           in   ADDR_WIDTH  sign-extended immediate
//  rd1             in   ADDR_WIDTH  register-file read port 1
//  halt            in   1           debug halt request
//  resume          in   1           debug resume request
//  PC              out  ADDR_WIDTH  current fetch PC (registered)
//  halted          out  1           1 while in HALT state
//  exc             out  1           1-cycle pulse: misaligned target trapped
//  epc             out  ADDR_WIDTH  PC of instruction whose target faulted
//  redirect_count  out  CNT_WIDTH   taken control transfers, saturating
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides all): PC=RESET_VECTOR, state=RUN, halted=0, exc=0, epc=0,
//   redirect_count=0, trace cleared. rst mid-halt or mid-stall returns to RUN immediately.
//  FSM RUN/HALT. RUN->HALT when halt=1 (PC unchanged that cycle, beats stall/jumps).
//   HALT->RUN when resume=1; PC unchanged; halt ignored in HALT; normal update resumes next cycle.
//   In HALT all of stall/PCsrc/jalrmuxSel ignored, counter/trace frozen.
//  RUN next-PC priority: stall > jalrmuxSel > PCsrc > PC+4. All adds modulo 2^ADDR_WIDTH (wrap).
//  Misaligned: jalr target bit1=1, or PCsrc target [1:0]!=0 -> PC<=TRAP_VECTOR, epc<=PC,
//   exc=1 for exactly the next cycle; not counted as redirect, not traced. Not checked if stall.
//  exc otherwise 0; epc holds last value until next fault or reset.
//  redirect_count +1 per accepted aligned jalr/PCsrc update; saturates at all-ones.
//  Latency: new PC visible one cycle after the deciding edge; no combinational input->PC path.
// CONFIGURATION
//  PC_TRACE_EN defined: adds ports trace_idx in $clog2(TRACE_DEPTH), trace_src out ADDR_WIDTH,
//   trace_dst out ADDR_WIDTH, trace_count out $clog2(TRACE_DEPTH)+1. Circular buffer records
//   {source PC, target} per counted redirect; full buffer overwrites oldest; trace_count
//   saturates at TRACE_DEPTH. Read combinational: trace_idx=0 is most recent;
//   trace_idx>=trace_count -> trace_src=trace_dst=0.
//  PC_TRACE_EN undefined: no trace ports, no buffer storage; all other behaviour identical.
// TESTING
//  T1 reset then 3 idle cycles -> PC 0,4,8,12; halted=0, exc=0, redirect_count=0.
//  T2 PC=0x10, PCsrc=1, ImmOp=0xFFFFFFF8 -> PC=0x08, count=1; with stall=1 same cycle -> PC=0x10, count=0.
//  T3 PC=0x20, jalrmuxSel=1, PCsrc=1, rd1=0x101, ImmOp=0 -> PC=0x100 (jalr wins, LSB cleared);
//     rd1=0x102 -> PC=TRAP_VECTOR, exc pulse 1 cycle, epc=0x20, count unchanged.
//  T4 halt=1 at PC=0x40 with PCsrc=1 -> halted=1, PC stays 0x40 for 5 cycles despite toggling
//     inputs; resume=1 -> halted=0, PC 0x40 then 0x44; rst during HALT -> PC=RESET_VECTOR, RUN.
//  T5 PC=0xFFFFFFFC, no jump -> PC=0x0 (wrap); CNT_WIDTH=2, 5 redirects -> count=3.
//  T6 PC_TRACE_EN, TRACE_DEPTH=4, 6 redirects -> trace_count=4, idx0=6th pair, idx3=3rd pair.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program counter with sequential/branch/jalr selection, stall, debug halt, misaligned-target trap
// and a saturating redirect counter. Define PC_TRACE_EN to add a circular buffer of recent redirects.
module pc_sequencer #(
  parameter int ADDR_WIDTH                = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(4),
  parameter int CNT_WIDTH                 = 16,
  parameter int TRACE_DEPTH               = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  PCsrc,
  input  logic                  jalrmuxSel,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  input  logic [ADDR_WIDTH-1:0] rd1,
  input  logic                  halt,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  halted,
  output logic                  exc,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [CNT_WIDTH-1:0]  redirect_count
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_WIDTH-1:0]          trace_src,
  output logic [ADDR_WIDTH-1:0]          trace_dst,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
`endif
);

  typedef enum logic {RUN, HALT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic                  exc_q, exc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic                  misaligned;

  // NOTE: combinational block assigns every output a default first, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    exc_d      = 1'b0;
    cnt_d      = cnt_q;
    redirect   = 1'b0;
    target     = pc_q + ImmOp;
    misaligned = 1'b0;

    if (jalrmuxSel) begin
      target     = (rd1 + ImmOp) & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
      misaligned = target[1];
    end else begin
      misaligned = (target[1:0] != 2'b00);
    end

    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (!stall) begin
          if (jalrmuxSel || PCsrc) begin
            if (misaligned) begin
              pc_d  = TRAP_VECTOR;
              epc_d = pc_q;
              exc_d = 1'b1;
            end else begin
              pc_d     = target;
              redirect = 1'b1;
              cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            pc_d = pc_q + ADDR_WIDTH'(4);
          end
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      exc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC             = pc_q;
  assign halted         = (state_q == HALT);
  assign exc            = exc_q;
  assign epc            = epc_q;
  assign redirect_count = cnt_q;

`ifdef PC_TRACE_EN
  localparam int TW = $clog2(TRACE_DEPTH);

  logic [ADDR_WIDTH-1:0] src_mem [TRACE_DEPTH];
  logic [ADDR_WIDTH-1:0] dst_mem [TRACE_DEPTH];
  logic [TW-1:0]         wptr_q, wptr_d;
  logic [TW:0]           tcnt_q, tcnt_d;
  logic [TW-1:0]         rptr;

  always_comb begin
    wptr_d = wptr_q;
    tcnt_d = tcnt_q;
    if (redirect) begin
      wptr_d = wptr_q + TW'(1);
      if (tcnt_q != (TW+1)'(TRACE_DEPTH)) tcnt_d = tcnt_q + (TW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      tcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      tcnt_q <= tcnt_d;
    end
  end

  // NOTE: storage is not reset; clearing the entry count is enough to hide stale contents.
  always_ff @(posedge clk) begin
    if (!rst && redirect) begin
      src_mem[wptr_q] <= pc_q;
      dst_mem[wptr_q] <= pc_d;
    end
  end

  // Most recent entry sits just behind the write pointer.
  assign rptr        = wptr_q - TW'(1) - trace_idx;
  assign trace_count = tcnt_q;
  assign trace_src   = ({1'b0, trace_idx} < tcnt_q) ? src_mem[rptr] : '0;
  assign trace_dst   = ({1'b0, trace_idx} < tcnt_q) ? dst_mem[rptr] : '0;
`endif

endmodule
